// File: rtl/mem_wb_stage.sv
// Memory / write-back stage: runs 32-bit loads and stores as two 16-bit halves
// against an asynchronous SRAM and holds the MEM/WB pipeline register.
// While an access is in flight, ready is low and upstream stages freeze.
module mem_wb_stage #(
    parameter int          SRAM_WAIT = 3,
    parameter logic [31:0] ADDR_BASE = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  dest_in,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic [31:0] Result_WB,
    output logic        WriteBackEn,
    output logic [3:0]  Dest_WB
);

    localparam int CNT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        result_wb_q, result_wb_d;
    logic               wb_en_q, wb_en_d;
    logic [3:0]         dest_wb_q, dest_wb_d;

    logic               req;
    logic               cnt_last;
    logic [16:0]        widx;
    logic               dq_oe;
    logic [15:0]        dq_out;

    // A simultaneous read and write request is handled as a read.
    assign req      = mem_r_en_in | mem_w_en_in;
    assign cnt_last = (cnt_q == CNT_W'(SRAM_WAIT - 1));
    // Word index of the byte offset from the data-memory base (wraps mod 2^32).
    assign widx     = 17'((alu_res_in - ADDR_BASE) >> 2);
    assign ready    = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);

    assign SRAM_DQ  = dq_oe ? dq_out : 16'hzzzz;

    // Access sequencer: IDLE -> LO -> HI -> DONE, each half held SRAM_WAIT cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                end
            end
            S_LO: begin
                if (cnt_last) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HI: begin
                if (cnt_last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // DONE still sees the frozen request; it must not start another access.
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // SRAM bus drive for the half currently being accessed.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        if ((state_q == S_LO) || (state_q == S_HI)) begin
            SRAM_ADDR = {widx, (state_q == S_HI)};
            if (mem_r_en_in) begin
                SRAM_OE_N = 1'b0;
            end else if (mem_w_en_in) begin
                SRAM_WE_N = 1'b0;
                dq_oe     = 1'b1;
                dq_out    = (state_q == S_HI) ? val_rm_in[31:16] : val_rm_in[15:0];
            end
        end
    end

    // Read-data capture on the final cycle of each half.
    always_comb begin
        rdata_d = rdata_q;
        if ((state_q == S_LO) && cnt_last) begin
            rdata_d[15:0] = SRAM_DQ;
        end else if ((state_q == S_HI) && cnt_last) begin
            rdata_d[31:16] = SRAM_DQ;
        end
    end

    // MEM/WB register: load on ready, otherwise insert a bubble and hold data.
    always_comb begin
        if (ready) begin
            wb_en_d     = wb_en_in;
            dest_wb_d   = dest_in;
            result_wb_d = mem_r_en_in ? rdata_q : alu_res_in;
        end else begin
            wb_en_d     = 1'b0;
            dest_wb_d   = dest_wb_q;
            result_wb_d = result_wb_q;
        end
    end

    // State and pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            result_wb_q <= '0;
            wb_en_q     <= 1'b0;
            dest_wb_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            result_wb_q <= result_wb_d;
            wb_en_q     <= wb_en_d;
            dest_wb_q   <= dest_wb_d;
        end
    end

    assign Result_WB   = result_wb_q;
    assign WriteBackEn = wb_en_q;
    assign Dest_WB     = dest_wb_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: drives instructions honouring ready, models a
// 16-bit SRAM, and scoreboards register-file write-backs.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] alu_res_in;
    logic [31:0] val_rm_in;
    logic [3:0]  dest_in;
    logic        ready;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic [31:0] result_wb;
    logic        write_back_en;
    logic [3:0]  dest_wb;

    int total = 0;
    int bad   = 0;

    logic [35:0] sb[$];
    logic [15:0] mem [0:15];

    logic [17:0] addr_log [0:15];
    logic [15:0] dq_log   [0:15];
    logic        we_log   [0:15];
    logic        oe_log   [0:15];

    mem_wb_stage #(.SRAM_WAIT(3), .ADDR_BASE(32'd1024)) dut (
        .clk(clk),
        .rst(rst),
        .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in),
        .val_rm_in(val_rm_in),
        .dest_in(dest_in),
        .ready(ready),
        .SRAM_ADDR(sram_addr),
        .SRAM_DQ(sram_dq),
        .SRAM_WE_N(sram_we_n),
        .SRAM_OE_N(sram_oe_n),
        .Result_WB(result_wb),
        .WriteBackEn(write_back_en),
        .Dest_WB(dest_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: drives data while read-enabled, writes on the clock while strobed.
    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[3:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Write-back monitor: every enabled write-back must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && write_back_en) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'(write_back_en), 32'd0);
            end else begin
                logic [35:0] e;
                e = sb.pop_front();
                check("wb_result", result_wb, e[31:0]);
                check("wb_dest", 32'(dest_wb), 32'(e[35:32]));
            end
        end
    end

    // Present one instruction, hold it until the stage accepts it, log the SRAM bus.
    task automatic issue(input logic wb, input logic rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] val,
                         input logic [3:0] dest, input logic [31:0] exp_res,
                         output int low);
        logic r;
        int   n;
        wb_en_in    = wb;
        mem_r_en_in = rd;
        mem_w_en_in = wr;
        alu_res_in  = alu;
        val_rm_in   = val;
        dest_in     = dest;
        low = 0;
        n   = 0;
        r   = 1'b0;
        do begin
            @(negedge clk);
            r = ready;
            if (n < 16) begin
                addr_log[n] = sram_addr;
                dq_log[n]   = sram_dq;
                we_log[n]   = sram_we_n;
                oe_log[n]   = sram_oe_n;
            end
            if (!r) low++;
            n++;
            @(posedge clk);
        end while (!r && n < 40);
        if (!r) check("accept_timeout", 32'(r), 32'd1);
        if (wb) sb.push_back({dest, exp_res});
        #1;
        wb_en_in    = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        alu_res_in  = '0;
        val_rm_in   = '0;
        dest_in     = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        rst = 1'b0;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        alu_res_in = '0; val_rm_in = '0; dest_in = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_wben", 32'(write_back_en), 32'd0);
        check("rst_result", result_wb, 32'd0);
        check("rst_dest", 32'(dest_wb), 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // ALU pass-through
        issue(1'b1, 1'b0, 1'b0, 32'h0000_00AB, 32'd0, 4'd5, 32'h0000_00AB, low);
        check("alu_ready_low", 32'(low), 32'd0);

        // Store 0xDEADBEEF to 1028
        issue(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd1, 32'd0, low);
        check("st_ready_low", 32'(low), 32'd7);
        check("st_idle_we", 32'(we_log[0]), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            check("st_addr", 32'(addr_log[i]), (i <= 3) ? 32'd2 : 32'd3);
            check("st_dq", 32'(dq_log[i]), (i <= 3) ? 32'h0000_BEEF : 32'h0000_DEAD);
            check("st_we_n", 32'(we_log[i]), 32'd0);
            check("st_oe_n", 32'(oe_log[i]), 32'd1);
        end
        check("st_done_we", 32'(we_log[7]), 32'd1);
        check("st_done_addr", 32'(addr_log[7]), 32'd0);

        // Load from 1028 then an ALU op
        issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd7, 32'hDEAD_BEEF, low);
        check("ld_ready_low", 32'(low), 32'd7);
        for (int i = 1; i <= 6; i++) begin
            check("ld_oe_n", 32'(oe_log[i]), 32'd0);
            check("ld_addr", 32'(addr_log[i]), (i <= 3) ? 32'd2 : 32'd3);
        end
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0011, 32'd0, 4'd2, 32'h0000_0011, low);
        check("alu2_ready_low", 32'(low), 32'd0);
        check("alu2_no_sram_oe", 32'(oe_log[0]), 32'd1);
        check("alu2_no_sram_we", 32'(we_log[0]), 32'd1);

        // Read/write conflict is a read
        issue(1'b1, 1'b1, 1'b1, 32'd1028, 32'h0BAD_F00D, 4'd9, 32'hDEAD_BEEF, low);
        check("rw_ready_low", 32'(low), 32'd7);
        for (int i = 0; i <= 7; i++) check("rw_we_n", 32'(we_log[i]), 32'd1);
        for (int i = 1; i <= 6; i++) check("rw_oe_n", 32'(oe_log[i]), 32'd0);

        // Address below base wraps
        issue(1'b0, 1'b0, 1'b1, 32'd1020, 32'h1234_5678, 4'd0, 32'd0, low);
        check("wrap_lo_addr", 32'(addr_log[1]), 32'h0003_FFFE);
        check("wrap_hi_addr", 32'(addr_log[4]), 32'h0003_FFFF);
        check("wrap_lo_dq", 32'(dq_log[2]), 32'h0000_5678);
        issue(1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 4'd4, 32'h1234_5678, low);
        check("wrap_ld_hi_addr", 32'(addr_log[6]), 32'h0003_FFFF);

        // Reset during the LO half of a store
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
        alu_res_in = 32'd1028; val_rm_in = 32'hCAFE_F00D; dest_in = 4'd6;
        @(negedge clk);
        @(negedge clk);
        check("mid_we_before", 32'(sram_we_n), 32'd0);
        #1 rst = 1'b0;
        #1;
        check("mid_we_n", 32'(sram_we_n), 32'd1);
        check("mid_oe_n", 32'(sram_oe_n), 32'd1);
        check("mid_addr", 32'(sram_addr), 32'd0);
        mem_w_en_in = 1'b0; alu_res_in = '0; val_rm_in = '0; dest_in = '0;
        #1;
        check("mid_ready", 32'(ready), 32'd1);
        check("mid_wben", 32'(write_back_en), 32'd0);
        check("mid_result", result_wb, 32'd0);
        check("mid_dest", 32'(dest_wb), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ready), 32'd1);
        check("post_rst_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd3, 32'hDEAD_BEEF, low);
        check("post_rst_ld_low", 32'(low), 32'd7);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
